// File: rtl/uart_tx.sv
// UART transmitter: start bit, NB_DATA data bits LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to include the parity bit; without it F_TX_PARITY has no effect.
module uart_tx #(
    parameter int         NB_DATA        = 8,
    parameter int         CLK_FREQ       = 100000000,
    parameter int         BAUD_RATE      = 115200,
    parameter logic [1:0] F_TX_PARITY    = 2'b01,
    parameter logic       F_TX_STOP_BITS = 1'b0
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_tx_data,
    output logic               o_tx,
    output logic               o_tx_busy,
    output logic               o_tx_done
);

    localparam int DIVISOR = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int IDX_W   = $clog2(NB_DATA);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB_DATA - 1);

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_ODD = (F_TX_PARITY == 2'b10);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

    state_t             state,     state_next;
    logic [CNT_W-1:0]   baud_cnt,  baud_cnt_next;
    logic [IDX_W-1:0]   bit_idx,   bit_idx_next;
    logic [NB_DATA-1:0] shift_reg, shift_reg_next;
    logic               stop_idx,  stop_idx_next;
    logic               tx_reg,    tx_next;
    logic               busy_reg,  busy_next;
    logic               done_reg,  done_next;
`ifdef UART_TX_PARITY_EN
    logic               parity_reg, parity_next;
`endif

    logic bit_end;

    assign bit_end   = (baud_cnt == CNT_LAST);
    assign o_tx      = tx_reg;
    assign o_tx_busy = busy_reg;
    assign o_tx_done = done_reg;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            stop_idx  <= 1'b0;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_reg_next;
            stop_idx  <= stop_idx_next;
            tx_reg    <= tx_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    // Outputs are computed one cycle ahead so every line transition comes straight from a flop.
    always_comb begin
        state_next     = state;
        baud_cnt_next  = bit_end ? '0 : baud_cnt + CNT_W'(1);
        bit_idx_next   = bit_idx;
        shift_reg_next = shift_reg;
        stop_idx_next  = stop_idx;
        tx_next        = tx_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next    = parity_reg;
`endif

        case (state)
            IDLE: begin
                baud_cnt_next = '0;
                tx_next       = 1'b1;
                busy_next     = 1'b0;
                if (i_tx_start) begin
                    state_next     = START;
                    shift_reg_next = i_tx_data;
                    tx_next        = 1'b0;
                    busy_next      = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_next    = (^i_tx_data) ^ PARITY_ODD;
`endif
                end
            end

            START: begin
                if (bit_end) begin
                    state_next     = DATA;
                    bit_idx_next   = '0;
                    tx_next        = shift_reg[0];
                    shift_reg_next = shift_reg >> 1;
                end
            end

            // Parity was latched at capture time because the shift register is consumed here.
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_next    = PARITY;
                        tx_next       = parity_reg;
`else
                        state_next    = STOP;
                        tx_next       = 1'b1;
                        stop_idx_next = 1'b0;
`endif
                    end else begin
                        bit_idx_next   = bit_idx + IDX_W'(1);
                        tx_next        = shift_reg[0];
                        shift_reg_next = shift_reg >> 1;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next    = STOP;
                    tx_next       = 1'b1;
                    stop_idx_next = 1'b0;
                end
            end
`endif

            STOP: begin
                tx_next = 1'b1;
                if (bit_end) begin
                    if (stop_idx == F_TX_STOP_BITS) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        stop_idx_next = 1'b1;
                    end
                end
            end

            default: begin
                state_next    = IDLE;
                baud_cnt_next = '0;
                tx_next       = 1'b1;
                busy_next     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: two instances (one stop bit / even parity, two stop bits / odd parity)
// compared cycle by cycle against a frame model built from the line protocol.
module tb_uart_tx;

    localparam int NB_DATA   = 8;
    localparam int CLK_FREQ  = 1000000;
    localparam int BAUD_RATE = 100000;
    localparam int DIV       = CLK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a, start_b;
    logic [7:0] data_a, data_b;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .NB_DATA(NB_DATA), .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE),
        .F_TX_PARITY(2'b01), .F_TX_STOP_BITS(1'b0)
    ) dut_a (
        .clk(clk), .i_rst_n(rst_n), .i_tx_start(start_a), .i_tx_data(data_a),
        .o_tx(tx_a), .o_tx_busy(busy_a), .o_tx_done(done_a)
    );

    uart_tx #(
        .NB_DATA(NB_DATA), .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE),
        .F_TX_PARITY(2'b10), .F_TX_STOP_BITS(1'b1)
    ) dut_b (
        .clk(clk), .i_rst_n(rst_n), .i_tx_start(start_b), .i_tx_data(data_b),
        .o_tx(tx_b), .o_tx_busy(busy_b), .o_tx_done(done_b)
    );

    // Line level for each bit slot: start low, data LSB first, optional parity, then idle-high stop bits.
    function automatic logic [15:0] frame_levels(input logic [7:0] d, input bit odd);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < NB_DATA; i++) f[1 + i] = d[i];
        if (PAR_EN != 0) f[1 + NB_DATA] = (^d) ^ odd;
        return f;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit sel, input logic s, input logic [7:0] d);
        if (sel) begin
            start_b = s;
            data_b  = d;
        end else begin
            start_a = s;
            data_a  = d;
        end
    endtask

    task automatic checkLine(input bit sel, input string tag, input logic tx, input logic busy, input logic done);
        checkOutput({tag, " tx"},   32'(sel ? tx_b : tx_a),     32'(tx));
        checkOutput({tag, " busy"}, 32'(sel ? busy_b : busy_a), 32'(busy));
        checkOutput({tag, " done"}, 32'(sel ? done_b : done_a), 32'(done));
    endtask

    // Called on a falling edge with the selected DUT idle; the start is accepted on the next rising edge.
    task automatic run_frame(input bit sel, input logic [7:0] d, input bit hold,
                             input int abort_at, input int inject_at);
        int          len;
        logic [15:0] f;
        len = 1 + NB_DATA + PAR_EN + (sel ? 2 : 1);
        f   = frame_levels(d, sel);
        applyStimulus(sel, 1'b1, d);
        @(posedge clk);
        for (int k = 1; k <= len * DIV; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) applyStimulus(sel, 1'b0, 8'($urandom));
            if (k == inject_at) applyStimulus(sel, 1'b1, 8'h12);
            if (k == inject_at + 1) applyStimulus(sel, 1'b0, 8'($urandom));
            checkLine(sel, $sformatf("d=%02h slot%0d", d, (k - 1) / DIV), f[(k - 1) / DIV], 1'b1, 1'b0);
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                checkLine(sel, "mid-frame reset", 1'b1, 1'b0, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        @(negedge clk);
        checkLine(sel, $sformatf("d=%02h done cycle", d), 1'b1, 1'b0, 1'b1);
        if (!hold) begin
            @(negedge clk);
            checkLine(sel, $sformatf("d=%02h after done", d), 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        checkLine(1'b0, "reset a", 1'b1, 1'b0, 1'b0);
        checkLine(1'b1, "reset b", 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        checkLine(1'b0, "idle a", 1'b1, 1'b0, 1'b0);

        run_frame(1'b0, 8'h55, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) run_frame(1'b0, 8'($urandom), 1'b0, 0, 0);

        run_frame(1'b0, 8'hF0, 1'b0, 0, 30);

        run_frame(1'b0, 8'h3C, 1'b1, 0, 0);
        run_frame(1'b0, 8'h3C, 1'b1, 0, 0);
        run_frame(1'b0, 8'h3C, 1'b0, 0, 0);

        run_frame(1'b1, 8'hA3, 1'b0, 0, 0);
        run_frame(1'b1, 8'($urandom), 1'b0, 0, 0);

        run_frame(1'b0, 8'h01, 1'b0, 0, 0);
        run_frame(1'b1, 8'h01, 1'b0, 0, 0);

        run_frame(1'b0, 8'($urandom), 1'b0, 45, 0);
        run_frame(1'b0, 8'h81, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
